// File: rtl/rv32_ctrl_pkg.sv
// Shared constants for the RV32I multicycle control path.
// Both the sequencing FSM and the controller decoder use these state codes.
package rv32_ctrl_pkg;

  // Control states; the numeric codes are visible on the state output
  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_MEMADR   = 5'd2,
    S_MEMRD    = 5'd3,
    S_MEMWB    = 5'd4,
    S_MEMWR    = 5'd5,
    S_RTYPE_EX = 5'd6,
    S_RTYPE_WB = 5'd7,
    S_BEQ      = 5'd8,
    S_ITYPE_EX = 5'd9,
    S_ITYPE_WB = 5'd10,
    S_JAL      = 5'd11,
    S_JALR     = 5'd12,
    S_BNE      = 5'd13,
    S_BLT      = 5'd14,
    S_BGE      = 5'd15,
    S_BLTU     = 5'd16,
    S_BGEU     = 5'd17,
    S_AUIPC    = 5'd18,
    S_LUI      = 5'd19
  } state_t;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Branch funct3 codes (instr[14:12]); 010 and 011 are undefined
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/main_fsm_if.sv
// Bundle between the instruction register / perf monitor and the sequencing FSM.
// master: the side that owns the instruction register and observes the FSM.
// slave:  the FSM itself.
interface main_fsm_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [4:0]       state;
  logic             instr_retired;
  logic             illegal_instr;
  logic [CNT_W-1:0] retired_count;
  logic [CNT_W-1:0] cycle_count;

  modport master (
    output opcode, funct3,
    input  state, instr_retired, illegal_instr, retired_count, cycle_count
  );

  modport slave (
    input  opcode, funct3,
    output state, instr_retired, illegal_instr, retired_count, cycle_count
  );
endinterface

// File: rtl/main_fsm_dispatch_decoder.sv
// DECODE-state dispatch: maps (opcode, funct3) to the first execution state.
// Anything undecodable targets FETCH and raises illegal.
module dispatch_decoder
  import rv32_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  output state_t     o_target,
  output logic       o_illegal
);

  // Opcode dispatch, with a nested funct3 split for conditional branches
  always_comb begin
    o_target  = S_FETCH;
    o_illegal = 1'b1;
    case (i_opcode)
      OP_LOAD, OP_STORE: begin o_target = S_MEMADR;   o_illegal = 1'b0; end
      OP_RTYPE:          begin o_target = S_RTYPE_EX; o_illegal = 1'b0; end
      OP_ITYPE:          begin o_target = S_ITYPE_EX; o_illegal = 1'b0; end
      OP_JAL:            begin o_target = S_JAL;      o_illegal = 1'b0; end
      OP_JALR:           begin o_target = S_JALR;     o_illegal = 1'b0; end
      OP_AUIPC:          begin o_target = S_AUIPC;    o_illegal = 1'b0; end
      OP_LUI:            begin o_target = S_LUI;      o_illegal = 1'b0; end
      OP_BRANCH: begin
        o_illegal = 1'b0;
        case (i_funct3)
          F3_BEQ:  o_target = S_BEQ;
          F3_BNE:  o_target = S_BNE;
          F3_BLT:  o_target = S_BLT;
          F3_BGE:  o_target = S_BGE;
          F3_BLTU: o_target = S_BLTU;
          F3_BGEU: o_target = S_BGEU;
          default: begin o_target = S_FETCH; o_illegal = 1'b1; end
        endcase
      end
      default: begin o_target = S_FETCH; o_illegal = 1'b1; end
    endcase
  end

endmodule

// File: rtl/main_fsm.sv
// RV32I multicycle sequencing FSM: control state register, next-state logic,
// registered retire/illegal pulses and performance counters.
module main_fsm
  import rv32_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic      clk,
  input  logic      reset,
  main_fsm_if.slave fsm_bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_retired;
  logic             r_illegal;
  logic [CNT_W-1:0] r_ret_cnt;
  logic [CNT_W-1:0] r_cyc_cnt;

  state_t           w_target;
  logic             w_dec_illegal;

  dispatch_decoder u_dispatch (
    .i_opcode  (fsm_bus.opcode),
    .i_funct3  (fsm_bus.funct3),
    .o_target  (w_target),
    .o_illegal (w_dec_illegal)
  );

  // State register, pulse registers and counters; pulses default low each
  // cycle so they last exactly one FETCH cycle after the terminating state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_retired <= 1'b0;
      r_illegal <= 1'b0;
      r_ret_cnt <= '0;
      r_cyc_cnt <= '0;
    end else begin
      r_cyc_cnt <= r_cyc_cnt + CNT_ONE;
      r_retired <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_FETCH:    r_state <= S_DECODE;
        S_DECODE: begin
          r_state   <= w_target;
          r_illegal <= w_dec_illegal;
        end
        S_MEMADR:   r_state <= (fsm_bus.opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
        S_MEMRD:    r_state <= S_MEMWB;
        S_RTYPE_EX: r_state <= S_RTYPE_WB;
        S_ITYPE_EX: r_state <= S_ITYPE_WB;
        S_MEMWB, S_MEMWR, S_RTYPE_WB, S_ITYPE_WB,
        S_BEQ, S_JAL, S_JALR, S_BNE, S_BLT, S_BGE, S_BLTU, S_BGEU,
        S_AUIPC, S_LUI: begin
          r_state   <= S_FETCH;
          r_retired <= 1'b1;
          r_ret_cnt <= r_ret_cnt + CNT_ONE;
        end
        // Unused encodings 20..31 only appear after corruption
        default: begin
          r_state   <= S_FETCH;
          r_illegal <= 1'b1;
        end
      endcase
    end
  end

  assign fsm_bus.state         = r_state;
  assign fsm_bus.instr_retired = r_retired;
  assign fsm_bus.illegal_instr = r_illegal;
  assign fsm_bus.retired_count = r_ret_cnt;
  assign fsm_bus.cycle_count   = r_cyc_cnt;

endmodule
